// File: rtl/puf_auth_ctrl.sv
// puf_auth_ctrl
//
// Challenge-response authenticator that initiates a PUF transaction.
// On an accepted start the challenge and enrolled response are latched.
// The challenge is presented with puf_signal high for SETTLE_CYCLES cycles,
// and the PUF response is sampled on the edge that lowers puf_signal.
// The Hamming distance to the enrolled response is then accumulated
// CHUNK bits per cycle and compared against HD_THRESHOLD.
//
// Ports:
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   start          - request authentication (sampled only when idle)
//   challenge_in   - challenge, latched on accepted start
//   expected_in    - enrolled response, latched on accepted start
//   puf_signal     - PUF signal strobe
//   puf_challenge  - PUF challenge, held until the next accepted start
//   puf_response   - PUF response
//   busy           - high from the accepting edge until back in idle
//   done           - one-cycle pulse when pass/hamming_dist are valid
//   pass           - hamming_dist <= HD_THRESHOLD
//   hamming_dist   - final Hamming distance
module puf_auth_ctrl #(
    parameter int unsigned WIDTH         = 128,
    parameter int unsigned CHUNK         = 8,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned HD_THRESHOLD  = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           challenge_in,
    input  logic [WIDTH-1:0]           expected_in,
    output logic                       puf_signal,
    output logic [WIDTH-1:0]           puf_challenge,
    input  logic [WIDTH-1:0]           puf_response,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [$clog2(WIDTH+1)-1:0] hamming_dist
);

    localparam int unsigned HDW    = $clog2(WIDTH + 1);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned IW     = $clog2(NCHUNK + 1);

    typedef enum logic [1:0] {StIdle, StSettle, StCount, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] chal_q, chal_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [HDW-1:0]   acc_q, acc_d;
    logic             sig_q, sig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [HDW-1:0]   hd_q, hd_d;
    logic [HDW-1:0]   sum;

    function automatic logic [HDW-1:0] popcnt(input logic [CHUNK-1:0] v);
        logic [HDW-1:0] c;
        c = '0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            c = c + HDW'(v[i]);
        end
        return c;
    endfunction

    // diff is shifted right each COUNT cycle, so the current chunk is always the low CHUNK bits.
    assign sum = acc_q + popcnt(diff_q[CHUNK-1:0]);

    always_comb begin
        state_d = state_q;
        chal_d  = chal_q;
        exp_d   = exp_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sig_d   = sig_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        hd_d    = hd_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    chal_d  = challenge_in;
                    exp_d   = expected_in;
                    sig_d   = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    hd_d    = '0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    diff_d  = puf_response ^ exp_q;
                    sig_d   = 1'b0;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = StCount;
                end
            end
            StCount: begin
                acc_d  = sum;
                idx_d  = idx_q + IW'(1);
                diff_d = diff_q >> CHUNK;
                if (idx_q == IW'(NCHUNK - 1)) begin
                    hd_d    = sum;
                    pass_d  = (32'(sum) <= HD_THRESHOLD);
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            chal_q  <= '0;
            exp_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            sig_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            hd_q    <= '0;
        end else begin
            state_q <= state_d;
            chal_q  <= chal_d;
            exp_q   <= exp_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            hd_q    <= hd_d;
        end
    end

    assign puf_signal    = sig_q;
    assign puf_challenge = chal_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign hamming_dist  = hd_q;

endmodule
